// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings,
// register word selects (reg_addr[4:2]) and default sizing.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_INSERV = 2'd2
  } irq_state_t;

  // Register selects, i.e. byte offset >> 2
  localparam logic [2:0] REG_MASK    = 3'd0;  // 0x00
  localparam logic [2:0] REG_PENDING = 3'd1;  // 0x04
  localparam logic [2:0] REG_EDGE    = 3'd2;  // 0x08
  localparam logic [2:0] REG_CUR     = 3'd3;  // 0x0C
  localparam logic [2:0] REG_EOI     = 3'd4;  // 0x10

  localparam int IRQ_NUM_SRC = 6;
  localparam int IRQ_ID_W    = 3;

  // CUR reports the id in a nibble-wide field with the in-service flag above it
  localparam int CUR_INSERV_BIT = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the highest priority.
// vld is high when any request bit is set; id is 0 otherwise.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC,
  parameter int ID_W    = IRQ_ID_W
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               vld
);

  // Scan from the lowest priority up so the lowest set index is the last write
  always_comb begin
    id  = '0;
    vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = ID_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Prioritising interrupt controller. Latches device interrupt lines into
// PENDING, masks them, picks the lowest-index eligible source and runs a
// req/ack handshake to CP0, holding the source in service until EOI.
// Optional feature macro: IRQ_EDGE_EN (EDGE register, per-source rising-edge
// capture and write-1-to-clear on PENDING). Without it every source is level.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC,
  parameter int ID_W    = IRQ_ID_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic [4:0]         reg_addr,
  input  logic               reg_we,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  irq_state_t         state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [2:0]         sel;
  logic               eoi_wr;
  logic               in_service;
  logic               unused_bits;

  assign sel         = reg_addr[4:2];
  assign eoi_wr      = reg_we && (sel == REG_EOI);
  assign in_service  = (state == ST_INSERV);
  assign eligible    = pend & mask;
  assign unused_bits = ^{reg_wdata[31:NUM_SRC], reg_addr[1:0]};

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req (eligible),
    .id  (win_id),
    .vld (win_vld)
  );

  // MASK register; a write takes effect for selection on the following cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (reg_we && (sel == REG_MASK)) begin
      mask <= reg_wdata[NUM_SRC-1:0];
    end
  end

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;

  assign rise    = irq_src & ~src_prev;
  assign w1c     = (reg_we && (sel == REG_PENDING)) ? reg_wdata[NUM_SRC-1:0] : '0;
  // Acknowledge consumes the edge event of the id currently being driven
  assign ack_clr = (state == ST_REQ && irq_ack) ? (NUM_SRC'(1) << irq_id) : '0;

  // EDGE register, previous-sample register and pending capture; a new edge beats any clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q   <= '0;
      src_prev <= '0;
      pend     <= '0;
    end else begin
      if (reg_we && (sel == REG_EDGE)) begin
        edge_q <= reg_wdata[NUM_SRC-1:0];
      end
      src_prev <= irq_src;
      pend     <= (irq_src & ~edge_q)
                | (edge_q & ((pend & ~w1c & ~ack_clr) | rise));
    end
  end
`else
  // Level-only build: PENDING is simply the registered source lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= irq_src;
    end
  end
`endif

  // Request/service FSM with registered irq_req and irq_id
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state   <= ST_REQ;
            irq_req <= 1'b1;
            irq_id  <= win_id;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state   <= ST_INSERV;
            irq_req <= 1'b0;
          end else if (!win_vld) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end else begin
            irq_id <= win_id;
          end
        end
        ST_INSERV: begin
          if (eoi_wr) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  // Bridge read mux, combinational from the address; unused bits read 0
  always_comb begin
    reg_rdata = '0;
    case (sel)
      REG_MASK:    reg_rdata[NUM_SRC-1:0] = mask;
      REG_PENDING: reg_rdata[NUM_SRC-1:0] = pend;
`ifdef IRQ_EDGE_EN
      REG_EDGE:    reg_rdata[NUM_SRC-1:0] = edge_q;
`endif
      REG_CUR: begin
        reg_rdata[CUR_INSERV_BIT] = in_service;
        reg_rdata[ID_W-1:0]       = irq_id;
      end
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: handshake, preemption, masking,
// level deassert, reset behaviour and (with IRQ_EDGE_EN) edge capture.
module tb_irq_controller;

  localparam int NUM_SRC = 6;
  localparam int ID_W    = 3;

  localparam logic [4:0] A_MASK    = 5'h00;
  localparam logic [4:0] A_PENDING = 5'h04;
  localparam logic [4:0] A_EDGE    = 5'h08;
  localparam logic [4:0] A_CUR     = 5'h0C;
  localparam logic [4:0] A_EOI     = 5'h10;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] irq_src;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic [4:0]         reg_addr;
  logic               reg_we;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;

  int tests = 0;
  int fails = 0;

  irq_controller #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_we    = 1'b1;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    irq_src   = '0;
    irq_ack   = 1'b0;
    reg_addr  = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_req", 32'(irq_req), 32'h0);
    chk("rst_id", 32'(irq_id), 32'h0);
    rd("rst_mask", A_MASK, 32'h0);
    rd("rst_pend", A_PENDING, 32'h0);
    rd("rst_cur", A_CUR, 32'h0);

    // 1: basic handshake on source 4
    wr(A_MASK, 32'hFFFF_FF3F);
    rd("t1_mask", A_MASK, 32'h3F);
    irq_src = 6'h10;
    tick();
    chk("t1_req_lat1", 32'(irq_req), 32'h0);
    tick();
    chk("t1_req", 32'(irq_req), 32'h1);
    chk("t1_id", 32'(irq_id), 32'h4);
    rd("t1_pend", A_PENDING, 32'h10);
    ack();
    chk("t1_req_ack", 32'(irq_req), 32'h0);
    rd("t1_cur_inserv", A_CUR, 32'h14);
    wr(A_EOI, 32'h0);
    rd("t1_cur_eoi", A_CUR, 32'h04);
    chk("t1_req_eoi", 32'(irq_req), 32'h0);
    tick();
    chk("t1_req_again", 32'(irq_req), 32'h1);
    chk("t1_id_again", 32'(irq_id), 32'h4);

    // 2: preemption by source 1 while requesting source 4
    irq_src = 6'h12;
    tick();
    chk("t2_id_before", 32'(irq_id), 32'h4);
    tick();
    chk("t2_id_preempt", 32'(irq_id), 32'h1);
    chk("t2_req", 32'(irq_req), 32'h1);
    ack();
    rd("t2_cur", A_CUR, 32'h11);
    irq_src = '0;
    wr(A_EOI, 32'h0);
    tick();
    chk("t2_idle", 32'(irq_req), 32'h0);

    // 3: masked source, then unmask
    wr(A_MASK, 32'h3E);
    irq_src = 6'h01;
    tick(); tick(); tick();
    chk("t3_masked", 32'(irq_req), 32'h0);
    wr(A_MASK, 32'h3F);
    chk("t3_mask_next", 32'(irq_req), 32'h0);
    tick();
    chk("t3_req", 32'(irq_req), 32'h1);
    chk("t3_id", 32'(irq_id), 32'h0);

    // 6: level source drops before ack
    irq_src = '0;
    tick();
    chk("t6_req_hold", 32'(irq_req), 32'h1);
    tick();
    chk("t6_req_fall", 32'(irq_req), 32'h0);
    rd("t6_cur", A_CUR, 32'h00);
    tick();
    chk("t6_stay_idle", 32'(irq_req), 32'h0);

`ifdef IRQ_EDGE_EN
    // 4: edge capture, ack clear, set-beats-W1C
    wr(A_EDGE, 32'h04);
    rd("t4_edge", A_EDGE, 32'h04);
    irq_src = 6'h04;
    tick();
    irq_src = '0;
    rd("t4_pend_latch", A_PENDING, 32'h04);
    tick();
    chk("t4_req", 32'(irq_req), 32'h1);
    chk("t4_id", 32'(irq_id), 32'h2);
    rd("t4_pend_held", A_PENDING, 32'h04);
    ack();
    rd("t4_pend_ackclr", A_PENDING, 32'h00);
    wr(A_EOI, 32'h0);
    irq_src = 6'h04;
    wr(A_PENDING, 32'h04);
    irq_src = '0;
    rd("t4_set_wins", A_PENDING, 32'h04);
    wr(A_PENDING, 32'h04);
    rd("t4_w1c", A_PENDING, 32'h00);
    wr(A_EDGE, 32'h0);
    tick(); tick();
    chk("t4_idle", 32'(irq_req), 32'h0);
`else
    // EDGE register absent: a write is dropped and the register reads 0
    wr(A_EDGE, 32'h3F);
    rd("t4_edge_zero", A_EDGE, 32'h00);
`endif

    // 5a: reset while in service
    irq_src = 6'h08;
    tick(); tick();
    chk("t5_req", 32'(irq_req), 32'h1);
    ack();
    rd("t5_cur_inserv", A_CUR, 32'h13);
    reset = 1'b1;
    #1;
    rd("t5_rst_cur", A_CUR, 32'h00);
    rd("t5_rst_mask", A_MASK, 32'h00);
    irq_src = '0;
    tick();
    reset = 1'b0;

    // 5b: reset while requesting
    wr(A_MASK, 32'h3F);
    irq_src = 6'h08;
    tick(); tick();
    chk("t5b_req", 32'(irq_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5b_rst_req", 32'(irq_req), 32'h0);
    rd("t5b_rst_pend", A_PENDING, 32'h00);
    rd("t5b_rst_mask", A_MASK, 32'h00);
    irq_src = '0;
    tick();
    reset = 1'b0;
    tick();

    // Stray ack and EOI after reset
    ack();
    chk("t5_stray_ack_req", 32'(irq_req), 32'h0);
    rd("t5_stray_ack_cur", A_CUR, 32'h00);
    wr(A_EOI, 32'h0);
    rd("t5_stray_eoi_cur", A_CUR, 32'h00);
    tick();
    chk("t5_stray_req", 32'(irq_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
